// File: rtl/not_not_round_engine.sv
// rtl/not_not_round_engine.sv - Not Not round generator and judge
// LFSR-driven prompt latch, answer mask, per-round timer, score and lives tracking.
module not_not_round_engine #(
  parameter int          COLOR_BITS     = 2,
  parameter int          NOT_BITS       = 2,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 50000000,
  parameter int          LIVES          = 3,
  parameter int          SCORE_W        = 8,
  localparam int         NUM_COLORS     = 2**COLOR_BITS
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic [NUM_COLORS-1:0]   answer,
  input  logic                    answer_valid,
  output logic [COLOR_BITS-1:0]   color_1_idx,
  output logic [COLOR_BITS-1:0]   color_2_idx,
  output logic [1:0]              logic_op,
  output logic [NOT_BITS-1:0]     not_count,
  output logic [NUM_COLORS-1:0]   target_mask,
  output logic                    round_active,
  output logic                    correct,
  output logic                    wrong,
  output logic                    timeout,
  output logic [SCORE_W-1:0]      score,
  output logic [3:0]              lives_left,
  output logic                    game_over
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LIVES_INIT = 4'(LIVES);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_WAIT, S_RESULT, S_OVER} state_t;

  state_t               state;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_next;
  logic [TIMER_W-1:0]   timer;

  logic [COLOR_BITS-1:0] gen_c1, gen_c2;
  logic [1:0]            gen_op;
  logic [NOT_BITS-1:0]   gen_nc;
  logic [NUM_COLORS-1:0] m1, m2, base, gen_mask;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  assign gen_c1 = lfsr[COLOR_BITS-1:0];
  assign gen_c2 = lfsr[2*COLOR_BITS-1:COLOR_BITS];
  assign gen_op = lfsr[9:8];
  assign gen_nc = lfsr[NOT_BITS+11:12];

  // Mask is derived from the same pre-advance lfsr that GEN latches, so it lines up with the prompt.
  always_comb begin
    m1 = '0;
    m2 = '0;
    m1[gen_c1] = 1'b1;
    m2[gen_c2] = 1'b1;
    case (gen_op)
      2'd0:    base = m1;
      2'd1:    base = m1 & m2;
      2'd2:    base = m1 | m2;
      default: base = m2;
    endcase
    gen_mask = gen_nc[0] ? ~base : base;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      lfsr         <= SEED_EFF;
      timer        <= '0;
      color_1_idx  <= '0;
      color_2_idx  <= '0;
      logic_op     <= '0;
      not_count    <= '0;
      target_mask  <= '0;
      round_active <= 1'b0;
      correct      <= 1'b0;
      wrong        <= 1'b0;
      timeout      <= 1'b0;
      score        <= '0;
      lives_left   <= LIVES_INIT;
      game_over    <= 1'b0;
    end else if (!enable) begin
      correct <= 1'b0;
      wrong   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      lfsr    <= lfsr_next;
      correct <= 1'b0;
      wrong   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            score      <= '0;
            lives_left <= LIVES_INIT;
            game_over  <= 1'b0;
            state      <= S_GEN;
          end
        end
        S_GEN: begin
          color_1_idx  <= gen_c1;
          color_2_idx  <= gen_c2;
          logic_op     <= gen_op;
          not_count    <= gen_nc;
          target_mask  <= gen_mask;
          timer        <= TIMER_LOAD;
          round_active <= 1'b1;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          // An answer on the final timer cycle wins over the timeout.
          if (answer_valid) begin
            round_active <= 1'b0;
            state        <= S_RESULT;
            if (answer == target_mask) begin
              correct <= 1'b1;
              if (score != {SCORE_W{1'b1}}) score <= score + 1'b1;
            end else begin
              wrong      <= 1'b1;
              lives_left <= lives_left - 4'd1;
            end
          end else if (timer == '0) begin
            round_active <= 1'b0;
            state        <= S_RESULT;
            timeout      <= 1'b1;
            lives_left   <= lives_left - 4'd1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_RESULT: begin
          if (lives_left == 4'd0) begin
            game_over <= 1'b1;
            state     <= S_OVER;
          end else begin
            state <= S_GEN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_not_not_round_engine.sv
// tb/tb_not_not_round_engine.sv - directed bench for not_not_round_engine
// Drives on negedge, samples on negedge; prompts are judged against an independent mask model.
module tb_not_not_round_engine;

  logic       clk = 1'b0;
  logic       reset, enable, start, answer_valid;
  logic [3:0] answer;
  logic [1:0] color_1_idx, color_2_idx, logic_op, not_count;
  logic [3:0] target_mask;
  logic       round_active, correct, wrong, timeout, game_over;
  logic [7:0] score;
  logic [3:0] lives_left;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] model_lfsr;

  always #5 clk = ~clk;

  not_not_round_engine #(
    .COLOR_BITS(2), .NOT_BITS(2), .SEED(16'h0000),
    .TIMEOUT_CYCLES(10), .LIVES(3), .SCORE_W(8)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .start(start),
    .answer(answer), .answer_valid(answer_valid),
    .color_1_idx(color_1_idx), .color_2_idx(color_2_idx),
    .logic_op(logic_op), .not_count(not_count), .target_mask(target_mask),
    .round_active(round_active), .correct(correct), .wrong(wrong),
    .timeout(timeout), .score(score), .lives_left(lives_left),
    .game_over(game_over)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Zero seed maps to 1.
  always @(posedge clk or posedge reset)
    if (reset) model_lfsr <= 16'h0001;
    else if (enable) model_lfsr <= lfsr_step(model_lfsr);

  function automatic logic [3:0] model_mask(input logic [1:0] c1, input logic [1:0] c2,
                                            input logic [1:0] op, input logic [1:0] nc);
    logic [3:0] a, b, r;
    a = 4'b0001 << c1;
    b = 4'b0001 << c2;
    case (op)
      2'd0: r = a;
      2'd1: r = a & b;
      2'd2: r = a | b;
      default: r = b;
    endcase
    return nc[0] ? ~r : r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_active();
    int cnt = 0;
    while (!round_active && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!round_active) check("round_start_timeout", 0, 1);
  endtask

  // kind: 0 correct answer, 1 wrong answer, 2 no answer, 3 no answer with a 5-cycle freeze
  task automatic do_round(input int kind, input int delay, input logic [3:0] wans,
                          input int exp_score, input int exp_lives, input int exp_len);
    int cnt;
    logic [3:0] exp_mask;
    wait_active();
    exp_mask = model_mask(color_1_idx, color_2_idx, logic_op, not_count);
    check("target_mask", target_mask, exp_mask);
    if (kind <= 1) begin
      repeat (delay) @(negedge clk);
      answer = (kind == 0) ? exp_mask : ((wans != 4'd0) ? wans : exp_mask ^ 4'b0001);
      answer_valid = 1'b1;
      @(negedge clk);
      answer_valid = 1'b0;
    end else begin
      cnt = 0;
      while (round_active && cnt < 100) begin
        if (kind == 3 && cnt == 2) enable = 1'b0;
        if (kind == 3 && cnt == 5) check("lfsr_frozen", dut.lfsr, model_lfsr);
        if (kind == 3 && cnt == 7) enable = 1'b1;
        @(negedge clk);
        cnt++;
      end
      check("round_len", cnt, exp_len);
    end
    check("correct", correct, kind == 0);
    check("wrong", wrong, kind == 1);
    check("timeout", timeout, kind >= 2);
    check("score", score, exp_score);
    check("lives", lives_left, exp_lives);
    @(negedge clk);
    check("pulse_width", correct | wrong | timeout, 0);
  endtask

  typedef struct {
    int kind; int delay; int exp_score; int exp_lives; int exp_len;
  } row_t;
  row_t rows[5];

  initial begin
    logic [15:0] nx;
    int found;
    rows[0] = '{kind: 0, delay: 0, exp_score: 1, exp_lives: 3, exp_len: 0};
    rows[1] = '{kind: 0, delay: 9, exp_score: 2, exp_lives: 3, exp_len: 0};
    rows[2] = '{kind: 1, delay: 9, exp_score: 2, exp_lives: 2, exp_len: 0};
    rows[3] = '{kind: 2, delay: 0, exp_score: 2, exp_lives: 1, exp_len: 10};
    rows[4] = '{kind: 1, delay: 4, exp_score: 2, exp_lives: 0, exp_len: 0};

    reset = 1'b1; enable = 1'b0; start = 1'b0; answer_valid = 1'b0; answer = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_lfsr", dut.lfsr, 16'h0001);
    check("reset_game_over", game_over, 0);
    check("reset_lives", lives_left, 3);
    check("reset_score", score, 0);
    check("reset_round_active", round_active, 0);
    check("reset_target_mask", target_mask, 0);
    reset = 1'b0;
    @(negedge clk);
    check("lfsr_held_disabled", dut.lfsr, 16'h0001);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("lfsr_one_step", dut.lfsr, 16'h0002);
    @(negedge clk);
    enable = 1'b1;

    // Game A: wait for an lfsr state that yields colour1=2, op=0, one not.
    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      nx = lfsr_step(model_lfsr);
      if (nx[1:0] == 2'd2 && nx[9:8] == 2'd0 && nx[13:12] == 2'd1) begin
        found = 1;
        pulse_start();
      end else begin
        @(negedge clk);
      end
    end
    check("seed_search_found", found, 1);
    wait_active();
    check("forced_color1", color_1_idx, 2);
    check("forced_op", logic_op, 0);
    check("forced_nots", not_count, 1);
    check("forced_mask", target_mask, 4'b1011);
    do_round(1, 0, 4'b0100, 0, 2, 0);
    do_round(0, 0, 4'd0, 1, 2, 0);
    do_round(2, 0, 4'd0, 1, 1, 10);
    do_round(2, 0, 4'd0, 1, 0, 10);
    check("gameA_over", game_over, 1);
    check("gameA_round_active", round_active, 0);

    // Game B: table of rounds, restarted from OVER.
    pulse_start();
    check("restart_score", score, 0);
    check("restart_lives", lives_left, 3);
    check("restart_game_over", game_over, 0);
    for (int r = 0; r < 5; r++)
      do_round(rows[r].kind, rows[r].delay, 4'd0, rows[r].exp_score, rows[r].exp_lives, rows[r].exp_len);
    check("gameB_over", game_over, 1);

    // Game C: three unanswered rounds, the first with a freeze mid-round.
    pulse_start();
    do_round(3, 0, 4'd0, 0, 2, 15);
    do_round(2, 0, 4'd0, 0, 1, 10);
    do_round(2, 0, 4'd0, 0, 0, 10);
    check("gameC_over", game_over, 1);
    check("gameC_round_active", round_active, 0);

    // Game D: reset during WAIT, then a long run of correct answers.
    pulse_start();
    do_round(1, 2, 4'd0, 0, 2, 0);
    do_round(0, 1, 4'd0, 1, 2, 0);
    wait_active();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_round_active", round_active, 0);
    check("midreset_pulses", correct | wrong | timeout, 0);
    check("midreset_score", score, 0);
    check("midreset_lives", lives_left, 3);
    check("midreset_mask", target_mask, 0);
    check("midreset_lfsr", dut.lfsr, 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 256; i++)
      do_round(0, 0, 4'd0, (i < 255) ? i + 1 : 255, 3, 0);
    check("score_saturated", score, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/not_not_round_engine.md
Name: not_not_round_engine

Overview:
- Parametrised round generator and judge for the Not Not game.
- Owns a free-running 16-bit LFSR and, each round, latches a prompt: two colour indices, a logic op and a not-count. It computes the required answer mask, then runs a per-round timeout.
- Judges the player's answer, keeps score and lives, and signals game over.
- Sits between the switch/key input conditioning and the HEX/LED/VGA prompt display logic.

Parameters:
- COLOR_BITS, 2, colour index width; NUM_COLORS = 2**COLOR_BITS, which is also the answer/target mask width.
- NOT_BITS, 2, not-count width; prompts range from 0 to 2**NOT_BITS-1 nots.
- SEED, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'h0001.
- TIMEOUT_CYCLES, 50000000, cycles allowed per round (must be ≥ 2).
- LIVES, 3, lives at game start (1..15).
- SCORE_W, 8, score counter width.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, the entire block freezes: LFSR, timer and FSM hold; pulses are suppressed.
- start  in  1  single-cycle pulse that begins a game from IDLE or OVER.
- answer  in  NUM_COLORS  player answer mask, sampled only when answer_valid=1.
- answer_valid  in  1  single-cycle pulse that submits answer.
- color_1_idx  out  COLOR_BITS  first prompt colour.
- color_2_idx  out  COLOR_BITS  second prompt colour.
- logic_op  out  2  0: colour1, 1: colour1 AND colour2, 2: colour1 OR colour2, 3: colour2.
- not_count  out  NOT_BITS  number of nots in the prompt.
- target_mask  out  NUM_COLORS  correct answer for the current prompt.
- round_active  out  1  high in WAIT only.
- correct  out  1  one-cycle pulse.
- wrong  out  1  one-cycle pulse.
- timeout  out  1  one-cycle pulse.
- score  out  SCORE_W  number of correct answers in this game.
- lives_left  out  4  remaining lives.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (async, high), all values hold while reset=1:
  - state=IDLE; lfsr=SEED (or 1 if SEED is 0); all prompt fields and target_mask=0.
  - Pulses=0, score=0, lives_left=LIVES, round_active=0, game_over=0.
- LFSR:
  - Fibonacci, shift left, feedback = b15^b13^b12^b10 into b0.
  - Advances every enabled cycle in every state. Never reaches 0.
- FSM states: IDLE, GEN, WAIT, RESULT, OVER.
  - IDLE: on start → GEN.
  - GEN, one cycle:
    - Latch color_1_idx=lfsr[COLOR_BITS-1:0] and color_2_idx=lfsr[2*COLOR_BITS-1:COLOR_BITS].
    - Latch logic_op=lfsr[9:8] and not_count=lfsr[NOT_BITS+11:12], all from the pre-advance lfsr value.
    - Load timer=TIMEOUT_CYCLES-1, then → WAIT.
    - Prompt fields and target_mask are valid from the first WAIT cycle and hold until the next GEN.
  - target_mask:
    - m1 = 1<<color_1_idx, m2 = 1<<color_2_idx.
    - Base = op-selected value of m1, m1&m2, m1|m2 or m2.
    - Inverted (bitwise NOT, NUM_COLORS bits) iff not_count is odd.
    - m1&m2 with different colours gives base 0, which is legal.
  - WAIT:
    - answer_valid=1: correct if answer==target_mask, else wrong. → RESULT.
    - Otherwise, timer==0: timeout. → RESULT.
    - Otherwise, timer decrements.
    - answer_valid in the same cycle as timer==0 counts as an answer; timeout is not raised.
  - Transition into RESULT: exactly one of correct/wrong/timeout is high for the single RESULT cycle.
    - The score/lives update is registered on the same edge.
    - correct: score+1, saturating at all-ones.
    - wrong or timeout: lives_left-1.
  - RESULT: lives_left==0 → OVER, else → GEN.
  - OVER:
    - game_over=1; prompt fields hold.
    - On start: score=0, lives_left=LIVES, → GEN.
- start is ignored outside IDLE and OVER. answer_valid is ignored outside WAIT.
- Latency: answer_valid at edge N → pulse and score visible after N; GEN after N+1; new prompt valid after N+2.
- Reset mid-round aborts immediately to IDLE; no pulse is emitted.

Test Plan:
- Reset with SEED=16'h0000 → lfsr=16'h0001. After enable=1 for 1 cycle → lfsr=16'h0002. game_over=0, lives_left=3, score=0.
- TIMEOUT_CYCLES=10, LIVES=3, start, no answer:
  - round_active stays high for exactly 10 cycles, then a single timeout pulse, lives_left=2.
  - After 3 such rounds → game_over=1, round_active=0.
- Each round, drive answer=target_mask computed by the bench model from color_1_idx/color_2_idx/logic_op/not_count → correct pulse, score increments.
  - 256 rounds with SCORE_W=8 → score saturates at 255.
- Force the prompt (seed search) to colour 1=2, op=0, not_count=1 → target_mask=4'b1011.
  - answer=4'b0100 → wrong, lives -1.
  - Next round answer=target_mask → correct.
- answer_valid asserted on the cycle the timer is 0 → correct or wrong only, no timeout.
  - enable=0 for 5 cycles in WAIT → timer and lfsr unchanged, round lasts 15 cycles total.
- Assert reset during WAIT → outputs at reset values asynchronously, no pulses. start after release → new round.
